// File: rtl/llc_buf_wb_pkg.sv
// Shared LLC constants, field types and the write-back FSM encoding.
package llc_buf_wb_pkg;

    localparam int WAYS         = 16;
    localparam int WAY_BITS     = 4;
    localparam int SET_BITS     = 10;
    localparam int LINE_BITS    = 128;
    localparam int TAG_BITS     = 16;
    localparam int STATE_BITS   = 3;
    localparam int OWNER_BITS   = 4;
    localparam int SHARERS_BITS = 16;
    localparam int HPROT_BITS   = 1;

    typedef logic [WAY_BITS-1:0]     llc_way_t;
    typedef logic [SET_BITS-1:0]     llc_set_t;
    typedef logic [LINE_BITS-1:0]    line_t;
    typedef logic [TAG_BITS-1:0]     llc_tag_t;
    typedef logic [STATE_BITS-1:0]   llc_state_t;
    typedef logic [OWNER_BITS-1:0]   owner_t;
    typedef logic [SHARERS_BITS-1:0] sharers_t;
    typedef logic [HPROT_BITS-1:0]   hprot_t;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WRITE = 2'd1,
        WB_EVICT = 2'd2,
        WB_DONE  = 2'd3
    } llc_wb_state_t;

endpackage

// File: rtl/llc_buf_wb_prio_enc.sv
// Lowest-set-bit encoder over the per-way pending mask.
module llc_buf_wb_prio_enc #(
    parameter int WAYS     = 16,
    parameter int WAY_BITS = 4
) (
    input  logic [WAYS-1:0]     req,
    output logic [WAY_BITS-1:0] idx,
    output logic                any
);

    // Scan from the top down so the lowest set bit wins last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = WAY_BITS'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/llc_buf_wb.sv
// Drain side of the LLC set buffer: writes modified ways, then the evict
// pointer if it changed, back to local memory and pulses completion.
module llc_buf_wb
    import llc_buf_wb_pkg::*;
#(
    parameter int WAYS         = llc_buf_wb_pkg::WAYS,
    parameter int WAY_BITS     = llc_buf_wb_pkg::WAY_BITS,
    parameter int SET_BITS     = llc_buf_wb_pkg::SET_BITS,
    parameter int LINE_BITS    = llc_buf_wb_pkg::LINE_BITS,
    parameter int TAG_BITS     = llc_buf_wb_pkg::TAG_BITS,
    parameter int STATE_BITS   = llc_buf_wb_pkg::STATE_BITS,
    parameter int OWNER_BITS   = llc_buf_wb_pkg::OWNER_BITS,
    parameter int SHARERS_BITS = llc_buf_wb_pkg::SHARERS_BITS,
    parameter int HPROT_BITS   = llc_buf_wb_pkg::HPROT_BITS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rst_state,
    input  logic                                 buf_wr_en,
    input  logic [WAY_BITS-1:0]                  buf_wr_way,
    input  logic                                 evict_upd,
    input  logic                                 wb_start,
    input  logic [SET_BITS-1:0]                  wb_set,
    input  logic [WAYS-1:0][LINE_BITS-1:0]       lines_buf,
    input  logic [WAYS-1:0][TAG_BITS-1:0]        tags_buf,
    input  logic [WAYS-1:0][STATE_BITS-1:0]      states_buf,
    input  logic [WAYS-1:0][OWNER_BITS-1:0]      owners_buf,
    input  logic [WAYS-1:0][SHARERS_BITS-1:0]    sharers_buf,
    input  logic [WAYS-1:0][HPROT_BITS-1:0]      hprots_buf,
    input  logic [WAYS-1:0]                      dirty_bits_buf,
    input  logic [WAY_BITS-1:0]                  evict_way_buf,
    input  logic                                 mem_wr_ready,
    output logic                                 mem_wr_valid,
    output logic                                 mem_wr_evict,
    output logic [SET_BITS-1:0]                  mem_wr_set,
    output logic [WAY_BITS-1:0]                  mem_wr_way,
    output logic [LINE_BITS-1:0]                 mem_wr_line,
    output logic [TAG_BITS-1:0]                  mem_wr_tag,
    output logic [STATE_BITS-1:0]                mem_wr_state,
    output logic [OWNER_BITS-1:0]                mem_wr_owner,
    output logic [SHARERS_BITS-1:0]              mem_wr_sharers,
    output logic [HPROT_BITS-1:0]                mem_wr_hprot,
    output logic                                 mem_wr_dirty,
    output logic [WAY_BITS-1:0]                  mem_wr_evict_way,
    output logic                                 wb_busy,
    output logic                                 wb_done
);

    llc_wb_state_t       state_q, state_d;
    logic [WAYS-1:0]     mod_mask, pending_q, wr_onehot, enc_onehot;
    logic                evict_flag, ev_q;
    logic [SET_BITS-1:0] set_q;
    logic [WAY_BITS-1:0] enc_idx;
    logic                enc_any;
    logic                start_ok, beat_acc, last_beat;

    llc_buf_wb_prio_enc #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_enc (
        .req (pending_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    // One-hot views of the same-cycle buffer write and the current beat's way.
    always_comb begin
        wr_onehot  = '0;
        enc_onehot = '0;
        if (buf_wr_en) wr_onehot[buf_wr_way] = 1'b1;
        if (enc_any)   enc_onehot[enc_idx]   = 1'b1;
    end

    // rst_state outranks a same-cycle wb_start in IDLE.
    assign start_ok  = (state_q == WB_IDLE) && wb_start && !rst_state;
    assign beat_acc  = (state_q == WB_WRITE) && mem_wr_ready;
    assign last_beat = (pending_q == enc_onehot);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= WB_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; rst_state aborts any in-flight sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WB_IDLE: begin
                if (start_ok) begin
                    if ((mod_mask | wr_onehot) != '0)  state_d = WB_WRITE;
                    else if (evict_flag || evict_upd)  state_d = WB_EVICT;
                    else                               state_d = WB_DONE;
                end
            end
            WB_WRITE: begin
                if (rst_state)                  state_d = WB_IDLE;
                else if (beat_acc && last_beat) state_d = ev_q ? WB_EVICT : WB_DONE;
            end
            WB_EVICT: begin
                if (rst_state)         state_d = WB_IDLE;
                else if (mem_wr_ready) state_d = WB_DONE;
            end
            WB_DONE:  state_d = WB_IDLE;
            default:  state_d = WB_IDLE;
        endcase
    end

    // Modified-way mask and evict flag: tracked only while idle, cleared on
    // completion or abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mod_mask   <= '0;
            evict_flag <= 1'b0;
        end else if (rst_state || state_q == WB_DONE) begin
            mod_mask   <= '0;
            evict_flag <= 1'b0;
        end else if (state_q == WB_IDLE) begin
            mod_mask   <= mod_mask | wr_onehot;
            evict_flag <= evict_flag | evict_upd;
        end
    end

    // Per-sequence snapshot: set, pending ways and evict request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_q     <= '0;
            pending_q <= '0;
            ev_q      <= 1'b0;
        end else if (start_ok) begin
            set_q     <= wb_set;
            pending_q <= mod_mask | wr_onehot;
            ev_q      <= evict_flag | evict_upd;
        end else if (rst_state) begin
            pending_q <= '0;
            ev_q      <= 1'b0;
        end else if (beat_acc) begin
            pending_q <= pending_q & ~enc_onehot;
        end
    end

    // Outputs decoded from state; data fields are zero outside their beat.
    always_comb begin
        mem_wr_valid     = (state_q == WB_WRITE);
        mem_wr_evict     = (state_q == WB_EVICT);
        wb_busy          = (state_q != WB_IDLE);
        wb_done          = (state_q == WB_DONE);
        mem_wr_set       = '0;
        mem_wr_way       = '0;
        mem_wr_line      = '0;
        mem_wr_tag       = '0;
        mem_wr_state     = '0;
        mem_wr_owner     = '0;
        mem_wr_sharers   = '0;
        mem_wr_hprot     = '0;
        mem_wr_dirty     = 1'b0;
        mem_wr_evict_way = '0;
        if (mem_wr_valid || mem_wr_evict) mem_wr_set = set_q;
        if (mem_wr_valid) begin
            mem_wr_way     = enc_idx;
            mem_wr_line    = lines_buf[enc_idx];
            mem_wr_tag     = tags_buf[enc_idx];
            mem_wr_state   = states_buf[enc_idx];
            mem_wr_owner   = owners_buf[enc_idx];
            mem_wr_sharers = sharers_buf[enc_idx];
            mem_wr_hprot   = hprots_buf[enc_idx];
            mem_wr_dirty   = dirty_bits_buf[enc_idx];
        end
        if (mem_wr_evict) mem_wr_evict_way = evict_way_buf;
    end

endmodule

// File: tb/tb_llc_buf_wb.sv
// Directed bench for llc_buf_wb: way beats, back-pressure, evict beat,
// same-cycle write at start, abort and async reset.
module tb_llc_buf_wb;

    logic                  clk = 1'b0;
    logic                  rst, rst_state, buf_wr_en, evict_upd, wb_start, mem_wr_ready;
    logic [3:0]            buf_wr_way, evict_way_buf;
    logic [9:0]            wb_set;
    logic [15:0][127:0]    lines_buf;
    logic [15:0][15:0]     tags_buf;
    logic [15:0][2:0]      states_buf;
    logic [15:0][3:0]      owners_buf;
    logic [15:0][15:0]     sharers_buf;
    logic [15:0][0:0]      hprots_buf;
    logic [15:0]           dirty_bits_buf;
    logic                  mem_wr_valid, mem_wr_evict, mem_wr_dirty, wb_busy, wb_done;
    logic [9:0]            mem_wr_set;
    logic [3:0]            mem_wr_way, mem_wr_owner, mem_wr_evict_way;
    logic [127:0]          mem_wr_line;
    logic [15:0]           mem_wr_tag, mem_wr_sharers;
    logic [2:0]            mem_wr_state;
    logic [0:0]            mem_wr_hprot;

    int n_chk  = 0;
    int n_fail = 0;

    llc_buf_wb dut (
        .clk(clk), .rst(rst), .rst_state(rst_state),
        .buf_wr_en(buf_wr_en), .buf_wr_way(buf_wr_way), .evict_upd(evict_upd),
        .wb_start(wb_start), .wb_set(wb_set),
        .lines_buf(lines_buf), .tags_buf(tags_buf), .states_buf(states_buf),
        .owners_buf(owners_buf), .sharers_buf(sharers_buf), .hprots_buf(hprots_buf),
        .dirty_bits_buf(dirty_bits_buf), .evict_way_buf(evict_way_buf),
        .mem_wr_ready(mem_wr_ready), .mem_wr_valid(mem_wr_valid), .mem_wr_evict(mem_wr_evict),
        .mem_wr_set(mem_wr_set), .mem_wr_way(mem_wr_way), .mem_wr_line(mem_wr_line),
        .mem_wr_tag(mem_wr_tag), .mem_wr_state(mem_wr_state), .mem_wr_owner(mem_wr_owner),
        .mem_wr_sharers(mem_wr_sharers), .mem_wr_hprot(mem_wr_hprot), .mem_wr_dirty(mem_wr_dirty),
        .mem_wr_evict_way(mem_wr_evict_way), .wb_busy(wb_busy), .wb_done(wb_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control/valid snapshot packed as {valid, evict, busy, done}.
    function automatic logic [3:0] ctl();
        return {mem_wr_valid, mem_wr_evict, wb_busy, wb_done};
    endfunction

    initial begin
        rst = 1'b0; rst_state = 1'b0; buf_wr_en = 1'b0; buf_wr_way = '0;
        evict_upd = 1'b0; wb_start = 1'b0; wb_set = '0; mem_wr_ready = 1'b0;
        evict_way_buf = 4'd5;
        for (int i = 0; i < 16; i++) begin
            lines_buf[i]      = {4{32'hC0DE_0000 | 32'(i)}};
            tags_buf[i]       = 16'h7000 | 16'(i);
            states_buf[i]     = 3'(i);
            owners_buf[i]     = ~4'(i);
            sharers_buf[i]    = 16'(1) << i;
            hprots_buf[i]     = 1'(i);
            dirty_bits_buf[i] = 1'(i >> 1);
        end

        // Reset state
        #12;
        chk("rst_ctl", 128'(ctl()), 128'h0);
        chk("rst_set", 128'(mem_wr_set), 128'h0);
        chk("rst_line", mem_wr_line, 128'h0);
        @(negedge clk); rst = 1'b1;
        tick();

        // Ways 3 and 9 modified, write-back to set 0x2A with ready high
        buf_wr_en = 1'b1; buf_wr_way = 4'd3; tick();
        buf_wr_way = 4'd9; tick();
        buf_wr_en = 1'b0; wb_start = 1'b1; wb_set = 10'h2A; mem_wr_ready = 1'b1; tick();
        wb_start = 1'b0;
        chk("t1_b0_ctl", 128'(ctl()), 128'b1010);
        chk("t1_b0_way", 128'(mem_wr_way), 128'd3);
        chk("t1_b0_set", 128'(mem_wr_set), 128'h2A);
        chk("t1_b0_line", mem_wr_line, {4{32'hC0DE0003}});
        chk("t1_b0_tag", 128'(mem_wr_tag), 128'h7003);
        chk("t1_b0_misc", 128'({mem_wr_state, mem_wr_owner, mem_wr_sharers, mem_wr_hprot, mem_wr_dirty}),
            128'({3'd3, 4'hC, 16'h0008, 1'b1, 1'b1}));
        tick();
        chk("t1_b1_ctl", 128'(ctl()), 128'b1010);
        chk("t1_b1_way", 128'(mem_wr_way), 128'd9);
        chk("t1_b1_line", mem_wr_line, {4{32'hC0DE0009}});
        chk("t1_b1_misc", 128'({mem_wr_tag, mem_wr_state, mem_wr_owner, mem_wr_sharers, mem_wr_hprot, mem_wr_dirty}),
            128'({16'h7009, 3'd1, 4'h6, 16'h0200, 1'b1, 1'b0}));
        tick();
        chk("t1_done", 128'(ctl()), 128'b0011);
        chk("t1_done_set", 128'(mem_wr_set), 128'h0);
        tick();
        chk("t1_idle", 128'(ctl()), 128'b0000);

        // Mask now empty, no evict: wb_done the very next cycle
        wb_start = 1'b1; wb_set = 10'h011; tick();
        wb_start = 1'b0;
        chk("t3_done", 128'(ctl()), 128'b0011);
        tick();
        chk("t3_idle", 128'(ctl()), 128'b0000);

        // Way 0 plus evict update, ready low two cycles on each beat
        buf_wr_en = 1'b1; buf_wr_way = 4'd0; evict_upd = 1'b1; tick();
        buf_wr_en = 1'b0; evict_upd = 1'b0;
        wb_start = 1'b1; wb_set = 10'h155; mem_wr_ready = 1'b0; tick();
        wb_start = 1'b0;
        chk("t2_w_ctl0", 128'(ctl()), 128'b1010);
        chk("t2_w_way0", 128'(mem_wr_way), 128'd0);
        chk("t2_w_line0", mem_wr_line, {4{32'hC0DE0000}});
        tick();
        chk("t2_w_ctl1", 128'(ctl()), 128'b1010);
        chk("t2_w_hold", 128'({mem_wr_set, mem_wr_tag, mem_wr_owner, mem_wr_sharers}),
            128'({10'h155, 16'h7000, 4'hF, 16'h0001}));
        mem_wr_ready = 1'b1; tick();
        mem_wr_ready = 1'b0;
        chk("t2_e_ctl0", 128'(ctl()), 128'b0110);
        chk("t2_e_data0", 128'({mem_wr_evict_way, mem_wr_set, mem_wr_line[0]}),
            128'({4'd5, 10'h155, 1'b0}));
        tick();
        chk("t2_e_ctl1", 128'(ctl()), 128'b0110);
        chk("t2_e_way1", 128'(mem_wr_evict_way), 128'd5);
        mem_wr_ready = 1'b1; tick();
        chk("t2_done", 128'(ctl()), 128'b0011);
        tick();
        chk("t2_idle", 128'(ctl()), 128'b0000);

        // Same-cycle write of way 15 at wb_start joins way 2
        buf_wr_en = 1'b1; buf_wr_way = 4'd2; tick();
        buf_wr_way = 4'd15; wb_start = 1'b1; wb_set = 10'h3FF; tick();
        buf_wr_en = 1'b0; wb_start = 1'b0;
        chk("t4_b0", 128'({ctl(), mem_wr_way, mem_wr_tag, mem_wr_dirty}),
            128'({4'b1010, 4'd2, 16'h7002, 1'b1}));
        tick();
        chk("t4_b1", 128'({ctl(), mem_wr_way, mem_wr_set, mem_wr_tag, mem_wr_state, mem_wr_sharers}),
            128'({4'b1010, 4'd15, 10'h3FF, 16'h700F, 3'd7, 16'h8000}));
        tick();
        chk("t4_done", 128'(ctl()), 128'b0011);
        tick();

        // Abort with three beats pending
        buf_wr_en = 1'b1; buf_wr_way = 4'd1; tick();
        buf_wr_way = 4'd4; tick();
        buf_wr_way = 4'd6; tick();
        buf_wr_en = 1'b0; wb_start = 1'b1; wb_set = 10'h0AB; mem_wr_ready = 1'b0; tick();
        wb_start = 1'b0;
        chk("t5_w", 128'({ctl(), mem_wr_way}), 128'({4'b1010, 4'd1}));
        rst_state = 1'b1; tick();
        rst_state = 1'b0;
        chk("t5_abort", 128'(ctl()), 128'b0000);
        mem_wr_ready = 1'b1; tick();
        chk("t5_nodone", 128'(ctl()), 128'b0000);
        wb_start = 1'b1; tick();
        wb_start = 1'b0;
        chk("t5_restart", 128'(ctl()), 128'b0011);
        tick();

        // Async reset in the middle of the evict beat
        evict_upd = 1'b1; tick();
        evict_upd = 1'b0; wb_start = 1'b1; wb_set = 10'h2C3; mem_wr_ready = 1'b0; tick();
        wb_start = 1'b0;
        chk("t6_evict", 128'({ctl(), mem_wr_evict_way, mem_wr_set}),
            128'({4'b0110, 4'd5, 10'h2C3}));
        #2 rst = 1'b0;
        #1;
        chk("t6_async_ctl", 128'(ctl()), 128'b0000);
        chk("t6_async_data", 128'({mem_wr_evict_way, mem_wr_set}), 128'h0);
        @(negedge clk); rst = 1'b1;
        tick();
        chk("t6_idle", 128'(ctl()), 128'b0000);
        wb_start = 1'b1; tick();
        wb_start = 1'b0;
        chk("t6_flag_clr", 128'(ctl()), 128'b0011);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
